// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-master arbiter for the unified memory port. A has fixed
//               priority; a saturating starvation counter guarantees B progress.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [2:0]        a_funct3,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [2:0]        b_funct3,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (RD_LATENCY < 1 || RD_LATENCY > 3 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
        $error("mem_port_arbiter: RD_LATENCY must be 1..3 and STARVE_MAX 1..15");
    end

    localparam logic [1:0] c_rd_lat     = 2'(RD_LATENCY);
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_WRITE_CD  = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_starve_cnt, w_starve_nxt;
    logic       r_rd_owner, w_rd_owner_nxt;   // 0 = port A, 1 = port B
    logic [1:0] r_lat_cnt, w_lat_nxt;
    logic       w_gnt_a, w_gnt_b, w_rvalid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
            r_rd_owner   <= 1'b0;
            r_lat_cnt    <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_rd_owner   <= w_rd_owner_nxt;
            r_lat_cnt    <= w_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_starve_nxt   = r_starve_cnt;
        w_rd_owner_nxt = r_rd_owner;
        w_lat_nxt      = r_lat_cnt;
        w_gnt_a        = 1'b0;
        w_gnt_b        = 1'b0;
        w_rvalid       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // B wins a contested cycle only once it has lost STARVE_MAX of them
                if (a_req && !(b_req && r_starve_cnt == c_starve_max)) begin
                    w_gnt_a = 1'b1;
                end else if (b_req) begin
                    w_gnt_b = 1'b1;
                end
                if (w_gnt_a || w_gnt_b) begin
                    w_lat_nxt      = 2'd1;
                    w_rd_owner_nxt = w_gnt_b;
                    w_state_nxt    = (w_gnt_b ? b_we : a_we) ? ST_WRITE_CD : ST_READ_WAIT;
                end
                if (w_gnt_b) begin
                    w_starve_nxt = 4'd0;
                end else if (w_gnt_a && b_req && r_starve_cnt != c_starve_max) begin
                    w_starve_nxt = r_starve_cnt + 4'd1;
                end
            end
            ST_READ_WAIT: begin
                if (r_lat_cnt == c_rd_lat) begin
                    w_rvalid    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_lat_nxt   = 2'd0;
                end else begin
                    w_lat_nxt = r_lat_cnt + 2'd1;
                end
            end
            ST_WRITE_CD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced to zero while reset is held, even with requests pending
    assign a_gnt      = reset & w_gnt_a;
    assign b_gnt      = reset & w_gnt_b;
    assign mem_en     = a_gnt | b_gnt;
    assign mem_we     = mem_en & (b_gnt ? b_we : a_we);
    assign mem_addr   = !reset ? '0 : (b_gnt ? b_addr   : a_addr);
    assign mem_wdata  = !reset ? '0 : (b_gnt ? b_wdata  : a_wdata);
    assign mem_funct3 = !reset ? '0 : (b_gnt ? b_funct3 : a_funct3);

    assign a_rvalid = reset & w_rvalid & ~r_rd_owner;
    assign b_rvalid = reset & w_rvalid &  r_rd_owner;
    assign a_rdata  = a_rvalid ? mem_rdata : '0;
    assign b_rdata  = b_rvalid ? mem_rdata : '0;
    assign busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter at RD_LATENCY 1, 2 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0, mem_rdata = '0;
    logic [2:0]  a_funct3 = '0, b_funct3 = '0;

    logic [2:0]  a_gnt, a_rvalid, b_gnt, b_rvalid, mem_en, mem_we, busy;
    logic [31:0] a_rdata [3];
    logic [31:0] b_rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [2:0]  mem_funct3 [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance i runs with RD_LATENCY = i+1; all share the same stimulus
    for (genvar i = 0; i < 3; i++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .RD_LATENCY(i + 1), .STARVE_MAX(4)
        ) u_dut (
            .clk(clk), .reset(reset),
            .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_funct3(a_funct3),
            .a_gnt(a_gnt[i]), .a_rvalid(a_rvalid[i]), .a_rdata(a_rdata[i]),
            .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_funct3(b_funct3),
            .b_gnt(b_gnt[i]), .b_rvalid(b_rvalid[i]), .b_rdata(b_rdata[i]),
            .mem_en(mem_en[i]), .mem_we(mem_we[i]), .mem_addr(mem_addr[i]),
            .mem_wdata(mem_wdata[i]), .mem_funct3(mem_funct3[i]),
            .mem_rdata(mem_rdata), .busy(busy[i])
        );
    end

    typedef struct {
        logic        a_req, a_we, b_req, b_we;
        logic        e_agnt, e_bgnt, e_en, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [2:0]  e_f3;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Leaves the bench just after a clock edge with reset released and all requests idle
    task automatic do_reset();
        reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Both masters hold read requests; A must win 4 contested grants, then B, then A
    task automatic starve_seq(input string tag);
        a_req = 1'b1; a_we = 1'b0; b_req = 1'b1; b_we = 1'b0;
        for (int c = 0; c < 12; c++) begin
            sample();
            chk($sformatf("%s_agnt_c%0d", tag, c), a_gnt[0], (c % 2 == 0 && c != 8) ? 1 : 0);
            chk($sformatf("%s_bgnt_c%0d", tag, c), b_gnt[0], (c == 8) ? 1 : 0);
            chk($sformatf("%s_brv_c%0d", tag, c), b_rvalid[0], (c == 9) ? 1 : 0);
            next_cycle();
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0, 32'h1111, 3'd2};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA0, 32'h1111, 3'd2};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 32'h1111, 3'd2};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB0, 32'h2222, 3'd5};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB0, 32'h2222, 3'd5};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA0, 32'h1111, 3'd2};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA0, 32'h1111, 3'd2};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 32'h1111, 3'd2};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0, 32'h1111, 3'd2};

        // Reset state with requests idle
        sample();
        chk("rst_busy", busy[0], 0);
        chk("rst_mem_en", mem_en[0], 0);
        chk("rst_a_gnt", a_gnt[0], 0);
        chk("rst_a_rvalid", a_rvalid[0], 0);

        // IDLE arbitration and memory-side muxing, one vector per fresh reset
        a_addr = 32'hA0; a_wdata = 32'h1111; a_funct3 = 3'd2;
        b_addr = 32'hB0; b_wdata = 32'h2222; b_funct3 = 3'd5;
        for (int v = 0; v < 9; v++) begin
            do_reset();
            a_req = vecs[v].a_req; a_we = vecs[v].a_we;
            b_req = vecs[v].b_req; b_we = vecs[v].b_we;
            sample();
            chk($sformatf("v%0d_a_gnt", v), a_gnt[0], vecs[v].e_agnt);
            chk($sformatf("v%0d_b_gnt", v), b_gnt[0], vecs[v].e_bgnt);
            chk($sformatf("v%0d_mem_en", v), mem_en[0], vecs[v].e_en);
            chk($sformatf("v%0d_mem_we", v), mem_we[0], vecs[v].e_we);
            chk($sformatf("v%0d_mem_addr", v), mem_addr[0], vecs[v].e_addr);
            chk($sformatf("v%0d_mem_wdata", v), mem_wdata[0], vecs[v].e_wdata);
            chk($sformatf("v%0d_mem_f3", v), 32'(mem_funct3[0]), 32'(vecs[v].e_f3));
            chk($sformatf("v%0d_busy", v), busy[0], 0);
        end

        // Single A read at RD_LATENCY=1, request held to probe the next grant slot
        do_reset();
        mem_rdata = 32'hDEADBEEF;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100;
        sample();
        chk("rd1_gnt_T", a_gnt[0], 1);
        chk("rd1_addr_T", mem_addr[0], 32'h100);
        chk("rd1_rvalid_T", a_rvalid[0], 0);
        next_cycle();
        sample();
        chk("rd1_gnt_T1", a_gnt[0], 0);
        chk("rd1_rvalid_T1", a_rvalid[0], 1);
        chk("rd1_rdata_T1", a_rdata[0], 32'hDEADBEEF);
        chk("rd1_b_rvalid_T1", b_rvalid[0], 0);
        chk("rd1_busy_T1", busy[0], 1);
        next_cycle();
        sample();
        chk("rd1_gnt_T2", a_gnt[0], 1);
        chk("rd1_rvalid_T2", a_rvalid[0], 0);
        chk("rd1_rdata_T2", a_rdata[0], 0);
        a_req = 1'b0;

        // A write with B read pending: turnaround cycle, then B
        do_reset();
        mem_rdata = 32'h12345678;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h55;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h40;
        sample();
        chk("wr_a_gnt_T", a_gnt[0], 1);
        chk("wr_b_gnt_T", b_gnt[0], 0);
        chk("wr_mem_we_T", mem_we[0], 1);
        chk("wr_addr_T", mem_addr[0], 32'h20);
        chk("wr_wdata_T", mem_wdata[0], 32'h55);
        next_cycle();
        a_req = 1'b0; a_we = 1'b0;
        sample();
        chk("wr_busy_T1", busy[0], 1);
        chk("wr_b_gnt_T1", b_gnt[0], 0);
        chk("wr_mem_en_T1", mem_en[0], 0);
        chk("wr_mem_we_T1", mem_we[0], 0);
        next_cycle();
        sample();
        chk("wr_b_gnt_T2", b_gnt[0], 1);
        chk("wr_addr_T2", mem_addr[0], 32'h40);
        chk("wr_mem_we_T2", mem_we[0], 0);
        next_cycle();
        b_req = 1'b0;
        sample();
        chk("wr_b_rvalid_T3", b_rvalid[0], 1);
        chk("wr_b_rdata_T3", b_rdata[0], 32'h12345678);
        chk("wr_a_rvalid_T3", a_rvalid[0], 0);

        // Starvation bound
        do_reset();
        starve_seq("stv");

        // RD_LATENCY=3: B read, A waits behind it
        do_reset();
        mem_rdata = 32'hCAFEF00D;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h300;
        sample();
        chk("l3_b_gnt_T", b_gnt[2], 1);
        next_cycle();
        b_req = 1'b0; a_req = 1'b1; a_we = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            sample();
            chk($sformatf("l3_busy_T%0d", k), busy[2], 1);
            chk($sformatf("l3_a_gnt_T%0d", k), a_gnt[2], 0);
            chk($sformatf("l3_b_rvalid_T%0d", k), b_rvalid[2], (k == 3) ? 1 : 0);
            chk($sformatf("l3_b_rdata_T%0d", k), b_rdata[2], (k == 3) ? 32'hCAFEF00D : 32'h0);
            next_cycle();
        end
        sample();
        chk("l3_a_gnt_T4", a_gnt[2], 1);
        chk("l3_busy_T4", busy[2], 0);
        a_req = 1'b0;

        // Reset during READ_WAIT at RD_LATENCY=2
        do_reset();
        mem_rdata = 32'h0BADF00D;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h500;
        sample();
        chk("rr_a_gnt_T", a_gnt[1], 1);
        next_cycle();
        reset = 1'b0;
        sample();
        chk("rr_a_gnt_rst", a_gnt[1], 0);
        chk("rr_busy_rst", busy[1], 0);
        chk("rr_mem_en_rst", mem_en[1], 0);
        chk("rr_mem_addr_rst", mem_addr[1], 0);
        chk("rr_a_rvalid_rst", a_rvalid[1], 0);
        chk("rr_a_rdata_rst", a_rdata[1], 0);
        a_req = 1'b0;
        next_cycle();
        sample();
        chk("rr_a_rvalid_rst2", a_rvalid[1], 0);
        reset = 1'b1;
        next_cycle();
        a_req = 1'b1;
        sample();
        chk("rr_a_rvalid_post", a_rvalid[1], 0);
        chk("rr_a_gnt_post", a_gnt[1], 1);
        next_cycle();
        a_req = 1'b0;
        sample();
        chk("rr_a_rvalid_post1", a_rvalid[1], 0);

        // B request withdrawn while A's read is outstanding
        do_reset();
        a_req = 1'b1; a_we = 1'b0;
        sample();
        chk("wd_a_gnt_T", a_gnt[0], 1);
        next_cycle();
        a_req = 1'b0; b_req = 1'b1;
        sample();
        chk("wd_b_gnt_T1", b_gnt[0], 0);
        chk("wd_busy_T1", busy[0], 1);
        next_cycle();
        b_req = 1'b0;
        sample();
        chk("wd_b_gnt_T2", b_gnt[0], 0);
        chk("wd_mem_en_T2", mem_en[0], 0);
        chk("wd_busy_T2", busy[0], 0);
        next_cycle();
        starve_seq("wd_stv");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
